sipo_rx_ctrl: RTL and testbench
===============================

Name: sipo_rx_ctrl

Overview:
Frame controller for the team's serial-in/parallel-out register path. It sequences the capture of one WIDTH-bit word from a gated serial bit stream. It counts bits and aborts frames that stall, then presents the completed word on a valid/ready output handshake. It sits between a serial front end (bit_valid/bit_in strobes) and any parallel consumer.

Parameters:
WIDTH, 8, data bits per frame (>=2)
TIMEOUT, 16, consecutive SHIFT-state cycles without bit_valid before the partial frame is aborted (>=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  frame-start strobe, one cycle
bit_valid  input  1  bit_in is a valid serial bit this cycle
bit_in  input  1  serial data bit
out_valid  output  1  out_data holds a completed frame
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  WIDTH  captured word, first bit at MSB
busy  output  1  high in SHIFT (and PARITY when enabled)
overrun  output  1  one-cycle pulse: a bit was dropped while in HOLD
timeout_err  output  1  one-cycle pulse: frame aborted by gap timeout
parity_err  output  1  parity result for the held frame; constant 0 without PARITY_EN

Behaviour:
- Reset (async, immediate): state=IDLE; shift register, bit count and gap count = 0; out_valid=0, out_data=0, busy=0, overrun=0, timeout_err=0, parity_err=0. Reset mid-frame discards the partial word.
- States: IDLE, SHIFT, HOLD, plus PARITY only under PARITY_EN.
- IDLE: bit_valid is ignored with no flag. A start moves the block to SHIFT and clears the bit count and gap count. If bit_valid is also high on the start cycle, that bit is captured as bit 0 (count=1).
- SHIFT: each bit_valid does shreg <= {shreg[WIDTH-2:0], bit_in} and count++. The bit that makes count==WIDTH moves the block to HOLD at that edge. On the same edge, out_data <= the final shifted word and out_valid <= 1. Latency is therefore one edge from the last bit to out_valid.
- start while in SHIFT is ignored.
- Gap timer: the count clears on every bit_valid. It increments on each SHIFT cycle without bit_valid. When the count reaches TIMEOUT-1 and the cycle again has no bit_valid, the block goes to IDLE. So TIMEOUT consecutive idle cycles cause the abort.
- On abort, timeout_err is high for exactly the following cycle. out_valid is not asserted and out_data keeps its previous value.
- HOLD: out_valid=1. out_data and parity_err are stable until the transfer edge (out_valid && out_ready).
- At the transfer edge out_valid drops, unless start is high in the same cycle. In that case the block goes directly to SHIFT with no idle cycle, and a coincident bit_valid is captured as bit 0.
- Any bit_valid in HOLD that is not captured by that back-to-back start rule is dropped, and overrun pulses for the next cycle. The held data is not modified.
- A start in HOLD without out_ready is ignored.
- busy = (state==SHIFT || state==PARITY).
- All outputs are registered. The widths of the bit count and gap count are set with $clog2.

Optional Feature:
PARITY_EN: when defined, the data bits are followed by one even-parity bit.
- After the WIDTH-th data bit the block enters PARITY instead of HOLD. The next bit_valid samples the parity bit and moves the block to HOLD.
- parity_err = (^data) ^ parity_bit, registered with out_valid.
- The gap timeout also applies in PARITY.
- When undefined, the PARITY state and logic are absent and parity_err is tied to 0.
- The port list is identical in both builds.

Decomposition:
- Package sipo_ctrl_pkg: state enum typedef (IDLE, SHIFT, HOLD, PARITY), state encoding width, and a default-TIMEOUT constant.
- Sub-module sipo_shift_reg (WIDTH): shift-enable, serial in, parallel out, async clear on rst. It is instantiated once and sequenced by the controller FSM.

Test Plan:
- Basic frame: start then bits 1,0,1,1,0,0,1,0 on consecutive cycles, out_ready=1 -> out_valid high for 1 cycle on the edge after the 8th bit, out_data=8'hB2, busy high for 8 cycles.
- Backpressure: capture 8'hB2 with out_ready=0 for 5 cycles, pulsing bit_valid twice in HOLD -> out_data stays 8'hB2, overrun pulses twice, out_valid holds until out_ready=1.
- Timeout: start, 3 bits, then 16 cycles without bit_valid -> return to IDLE at the 16th idle edge, timeout_err high one cycle, busy=0, out_valid never asserted.
- Back-to-back: hold 8'hB2, then raise out_ready and start together, then send 8 ones -> first word transferred, second frame captured with no idle gap, out_data=8'hFF.
- Reset mid-frame: assert rst after 4 bits -> all outputs 0 immediately. After release, a full frame 1,1,1,1,0,0,0,0 yields out_data=8'hF0.
- PARITY_EN build: send 8'hB2 plus parity bit 0 -> parity_err=0. Send 8'hB2 plus parity bit 1 -> parity_err=1, asserted together with out_valid.

Source files
------------

// File: rtl/sipo_ctrl_pkg.sv
// Shared types and constants for the serial-in/parallel-out frame controller.
package sipo_ctrl_pkg;

  localparam int unsigned STATE_W         = 2;
  localparam int unsigned DEFAULT_TIMEOUT = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    SHIFT,
    HOLD,
    PARITY
  } state_t;

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit serial-in/parallel-out shift register, MSB-first, async clear.
module sipo_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Frame controller: captures one WIDTH-bit serial word, aborts stalled frames,
// presents the word on a valid/ready handshake. Define PARITY_EN for an even-parity bit.
module sipo_rx_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err,
  output logic             parity_err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned GAP_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [GAP_W-1:0]   gap, gap_n;
  logic [WIDTH-1:0]   shreg, next_word, out_data_n;
  logic               shift_en, gap_run;
  logic               out_valid_n, busy_n, overrun_n, timeout_n;
`ifdef PARITY_EN
  logic               parity_n;
`endif

  sipo_shift_reg #(.WIDTH(WIDTH)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .din      (bit_in),
    .q        (shreg)
  );

  // Word as it will look after the current bit shifts in (drops the old MSB).
  assign next_word = WIDTH'({shreg, bit_in});

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    gap_n       = gap;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    overrun_n   = 1'b0;
    timeout_n   = 1'b0;
    shift_en    = 1'b0;
    gap_run     = 1'b0;
`ifdef PARITY_EN
    parity_n    = parity_err;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = SHIFT;
          gap_n    = '0;
          cnt_n    = CNT_W'(bit_valid);
          shift_en = bit_valid;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          shift_en = 1'b1;
          gap_n    = '0;
          cnt_n    = cnt + 1'b1;
          if (cnt == LAST_BIT) begin
`ifdef PARITY_EN
            state_n     = PARITY;
`else
            state_n     = HOLD;
            out_valid_n = 1'b1;
            out_data_n  = next_word;
`endif
          end
        end else begin
          gap_run = 1'b1;
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bit_valid) begin
          state_n     = HOLD;
          gap_n       = '0;
          out_valid_n = 1'b1;
          out_data_n  = shreg;
          parity_n    = (^shreg) ^ bit_in;
        end else begin
          gap_run = 1'b1;
        end
      end
`endif
      HOLD: begin
        if (bit_valid && !(out_ready && start)) begin
          overrun_n = 1'b1;
        end
        if (out_ready) begin
          out_valid_n = 1'b0;
          if (start) begin
            state_n  = SHIFT;
            gap_n    = '0;
            cnt_n    = CNT_W'(bit_valid);
            shift_en = bit_valid;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (gap_run) begin
      if (gap == GAP_MAX) begin
        state_n   = IDLE;
        timeout_n = 1'b1;
      end else begin
        gap_n = gap + 1'b1;
      end
    end

    busy_n = (state_n == SHIFT) || (state_n == PARITY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      gap         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
`ifdef PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      gap         <= gap_n;
      out_valid   <= out_valid_n;
      out_data    <= out_data_n;
      busy        <= busy_n;
      overrun     <= overrun_n;
      timeout_err <= timeout_n;
`ifdef PARITY_EN
      parity_err  <= parity_n;
`endif
    end
  end

`ifndef PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Self-checking bench for sipo_rx_ctrl: directed scenarios plus random traffic
// against a bit-queue reference model.
module tb_sipo_rx_ctrl;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;
`ifdef PARITY_EN
  localparam int NEED = WIDTH + 1;
`else
  localparam int NEED = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst, start, bit_valid, bit_in, out_ready;
  logic             out_valid, busy, overrun, timeout_err, parity_err;
  logic [WIDTH-1:0] out_data;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 waiting, 1 collecting, 2 holding a word.
  int               phase;
  int               gap;
  bit               q_bits[$];
  logic             m_valid, m_ovr, m_to, m_perr;
  logic [WIDTH-1:0] m_data;

  sipo_rx_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    phase = 0; gap = 0; q_bits.delete();
    m_valid = 0; m_data = '0; m_ovr = 0; m_to = 0; m_perr = 0;
  endtask

  task automatic begin_frame(input logic bv, input logic bi);
    phase = 1; gap = 0; q_bits.delete();
    if (bv) q_bits.push_back(bi);
  endtask

  task automatic model_step(input logic s, input logic bv, input logic bi, input logic rdy);
    m_ovr = 0; m_to = 0;
    case (phase)
      0: if (s) begin_frame(bv, bi);
      1: begin
        if (bv) begin
          q_bits.push_back(bi);
          gap = 0;
          if (q_bits.size() == NEED) begin
            phase = 2;
            m_valid = 1;
            for (int i = 0; i < WIDTH; i++) m_data[WIDTH-1-i] = q_bits[i];
`ifdef PARITY_EN
            m_perr = 0;
            foreach (q_bits[i]) m_perr = m_perr ^ q_bits[i];
`endif
          end
        end else begin
          gap++;
          if (gap == TIMEOUT) begin
            phase = 0;
            m_to = 1;
          end
        end
      end
      default: begin
        if (bv && !(rdy && s)) m_ovr = 1;
        if (rdy) begin
          m_valid = 0;
          if (s) begin_frame(bv, bi);
          else phase = 0;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk1("out_valid", out_valid, m_valid);
    chkw("out_data", out_data, m_data);
    chk1("busy", busy, phase == 1);
    chk1("overrun", overrun, m_ovr);
    chk1("timeout_err", timeout_err, m_to);
    chk1("parity_err", parity_err, m_perr);
  endtask

  task automatic step(input logic s, input logic bv, input logic bi, input logic rdy);
    start = s; bit_valid = bv; bit_in = bi; out_ready = rdy;
    @(posedge clk);
    model_step(s, bv, bi, rdy);
    #1;
    check_all();
    start = 0; bit_valid = 0; bit_in = 0;
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] word, input logic rdy);
    for (int i = WIDTH - 1; i >= 0; i--) step(0, 1, word[i], rdy);
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] word, input logic rdy);
    step(1, 0, 0, rdy);
    send_bits(word, rdy);
`ifdef PARITY_EN
    step(0, 1, ^word, rdy);
`endif
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, "_valid"}, out_valid, 1'b0);
    chkw({tag, "_data"}, out_data, '0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_ovr"}, overrun, 1'b0);
    chk1({tag, "_to"}, timeout_err, 1'b0);
    chk1({tag, "_par"}, parity_err, 1'b0);
  endtask

  initial begin
    logic s, bv, bi, rdy;
    int   thresh;
    rst = 1; start = 0; bit_valid = 0; bit_in = 0; out_ready = 0;
    model_reset();
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Basic frame with consumer always ready
    send_frame(8'hB2, 1);
    chk1("basic_valid", out_valid, 1'b1);
    chkw("basic_data", out_data, 8'hB2);
    step(0, 0, 0, 1);
    chk1("basic_valid_drop", out_valid, 1'b0);

    // Backpressure with two dropped bits while holding
    send_frame(8'hB2, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    chk1("bp_overrun", overrun, 1'b1);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chkw("bp_data", out_data, 8'hB2);
    chk1("bp_valid", out_valid, 1'b1);

    // Back-to-back: transfer and restart on the same edge
    step(1, 0, 0, 1);
    chk1("b2b_busy", busy, 1'b1);
    send_bits(8'hFF, 0);
`ifdef PARITY_EN
    step(0, 1, 0, 0);
`endif
    chkw("b2b_data", out_data, 8'hFF);
    step(0, 0, 0, 1);

    // Gap timeout after three bits
    step(1, 0, 0, 1);
    repeat (3) step(0, 1, 1, 1);
    repeat (TIMEOUT - 1) step(0, 0, 0, 1);
    chk1("to_busy_before", busy, 1'b1);
    step(0, 0, 0, 1);
    chk1("to_flag", timeout_err, 1'b1);
    chk1("to_busy_after", busy, 1'b0);
    chk1("to_no_valid", out_valid, 1'b0);
    step(0, 0, 0, 1);
    chk1("to_flag_pulse", timeout_err, 1'b0);

    // Reset in the middle of a frame
    step(1, 0, 0, 1);
    repeat (4) step(0, 1, 1, 1);
    #2 rst = 1;
    #1;
    check_zero("midrst");
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    send_frame(8'hF0, 1);
    chkw("after_rst_data", out_data, 8'hF0);
    step(0, 0, 0, 1);

`ifdef PARITY_EN
    // Good and bad parity bits
    step(1, 0, 0, 0);
    send_bits(8'hB2, 0);
    step(0, 1, 0, 0);
    chk1("par_ok", parity_err, 1'b0);
    step(1, 0, 0, 1);
    send_bits(8'hB2, 0);
    step(0, 1, 1, 0);
    chk1("par_bad_valid", out_valid, 1'b1);
    chk1("par_bad", parity_err, 1'b1);
    step(0, 0, 0, 1);
`endif

    // Random traffic with varying bit density
    for (int blk = 0; blk < 8; blk++) begin
      case (blk % 4)
        0: thresh = 8;
        1: thresh = 6;
        2: thresh = 3;
        default: thresh = 1;
      endcase
      for (int n = 0; n < 400; n++) begin
        s   = ($urandom_range(0, 19) == 0);
        bv  = (int'($urandom_range(0, 7)) < thresh);
        bi  = $urandom_range(0, 1) != 0;
        rdy = ($urandom_range(0, 3) != 0);
        step(s, bv, bi, rdy);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
